wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-low.
REQ-005 ex_valid_i / ex_rd_addr_i / ex_rd_data_i  in  1/5/XLEN  ALU result write request.
REQ-006 ex_ready_o  out  1  ALU request accepted this cycle when high with ex_valid_i.
REQ-007 mem_valid_i / mem_rd_addr_i / mem_rd_data_i  in  1/5/XLEN  load result write request.
REQ-008 mem_ready_o  out  1  load request accepted this cycle when high with mem_valid_i.
REQ-009 wb_stall_i  in  1  register file write port unavailable this cycle.
REQ-010 rd_we_o / rd_addr_o / rd_data_o  out  1/5/XLEN  write port into register file.
REQ-011 rs1_addr_i / rs2_addr_i  in  5/5  decode source register addresses.
REQ-012 rs1_pending_o / rs2_pending_o  out  1/1  source has an unwritten queued result.
REQ-013 rs1_fwd_data_o / rs2_fwd_data_o  out  XLEN/XLEN  youngest queued data for that source.
REQ-014 count_o  out  clog2(DEPTH)+1  current number of queued entries.

Function
REQ-015 Queue SHALL be a circular FIFO of DEPTH {addr,data} entries with wrapping read/write pointers and an occupancy counter.
REQ-016 full = (count==DEPTH); empty = (count==0).
REQ-017 mem_ready_o SHALL equal !full; ex_ready_o SHALL equal !full && !mem_valid_i (load has priority, at most one push per cycle).
REQ-018 Ready outputs SHALL NOT depend on wb_stall_i; a full queue refuses pushes even in a pop cycle.
REQ-019 An accepted request with rd_addr==0 SHALL complete its handshake but SHALL NOT be enqueued (x0 never written).
REQ-020 rd_we_o SHALL be !empty && !wb_stall_i, combinational; when high, rd_addr_o/rd_data_o SHALL be the head entry and the head SHALL pop at that clock edge.
REQ-021 When rd_we_o is low, rd_addr_o and rd_data_o SHALL be 0.
REQ-022 Latency: request accepted at edge N into an empty queue SHALL appear with rd_we_o high in cycle N+1 if wb_stall_i low.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; push only increments; pop only decrements.
REQ-024 Entries SHALL drain strictly in acceptance order, one per unstalled cycle.
REQ-025 rsX_pending_o SHALL be 1 iff rsX_addr_i!=0 and any valid entry (including the head being written this cycle) has matching addr.
REQ-026 rsX_fwd_data_o SHALL be data of the youngest matching valid entry; 0 when rsX_pending_o is 0.
REQ-027 Pending/forward outputs SHALL be combinational from current queue state and rsX_addr_i; same-cycle incoming requests are not considered.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless with no lost or duplicated entry.

Reset
REQ-029 While rst_i is low at a rising edge: pointers, count_o SHALL clear to 0; all queued entries discarded and never written.
REQ-030 During and after reset: rd_we_o=0, rd_addr_o=0, rd_data_o=0, pending=0, fwd_data=0, count_o=0; ready outputs SHALL be 0 while rst_i is low.
REQ-031 Entry storage contents need not be reset; validity derives only from pointers/count.

Verification
REQ-032 Single write: ex_valid_i=1, addr=5, data=0xDEADBEEF, stall=0 -> next cycle rd_we_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF; count_o back to 0 after.
REQ-033 Priority: ex and mem both valid (addr 3/4) -> mem_ready_o=1, ex_ready_o=0; addr 4 written first; ex accepted next cycle, addr 3 written after.
REQ-034 Fill/stall: wb_stall_i=1, push 5 requests (addr 1..5) -> 4 accepted, count_o=4, both readies 0; release stall -> writes 1,2,3,4 in order on 4 consecutive cycles.
REQ-035 Forwarding: stall, queue addr 7 data 0x11 then addr 7 data 0x22, rs1_addr_i=7, rs2_addr_i=0 -> rs1_pending_o=1, rs1_fwd_data_o=0x22, rs2_pending_o=0.
REQ-036 x0 and reset: push addr 0 -> handshake completes, count_o stays 0, rd_we_o never 1; queue 3 entries, assert rst_i=0 one edge -> count_o=0, no writes follow.
REQ-037 Wrap: sustained push/pop for 3*DEPTH entries with random stall -> every entry written exactly once, in order.

Source files
------------

// File: rtl/wb_queue.sv
// Write-back queue: buffers ALU and load results in a circular FIFO ahead of
// the register file write port. It also reports which decode source registers
// still have a queued result, and forwards the youngest queued value for each.
//
// Handshake: a request is accepted on a rising edge where valid and ready are
// both high. Ready never depends on valid of the same port or on wb_stall_i.
// Load requests take priority, so at most one entry is pushed per cycle.
module wb_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ex_valid_i,
  input  logic [4:0]               ex_rd_addr_i,
  input  logic [XLEN-1:0]          ex_rd_data_i,
  output logic                     ex_ready_o,
  input  logic                     mem_valid_i,
  input  logic [4:0]               mem_rd_addr_i,
  input  logic [XLEN-1:0]          mem_rd_data_i,
  output logic                     mem_ready_o,
  input  logic                     wb_stall_i,
  output logic                     rd_we_o,
  output logic [4:0]               rd_addr_o,
  output logic [XLEN-1:0]          rd_data_o,
  input  logic [4:0]               rs1_addr_i,
  input  logic [4:0]               rs2_addr_i,
  output logic                     rs1_pending_o,
  output logic                     rs2_pending_o,
  output logic [XLEN-1:0]          rs1_fwd_data_o,
  output logic [XLEN-1:0]          rs2_fwd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry storage; validity comes only from the pointers and the count.
  logic [4:0]      r_addr [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];

  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_mem_ready;
  logic            w_ex_ready;
  logic            w_mem_acc;
  logic            w_ex_acc;
  logic            w_push;
  logic            w_pop;
  logic [4:0]      w_push_addr;
  logic [XLEN-1:0] w_push_data;

  logic            w_rs1_hit;
  logic            w_rs2_hit;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [AW-1:0]   w_idx;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Ready is forced low while reset is asserted, since state is not yet valid.
  assign w_mem_ready = rst_i && !w_full;
  assign w_ex_ready  = rst_i && !w_full && !mem_valid_i;
  assign mem_ready_o = w_mem_ready;
  assign ex_ready_o  = w_ex_ready;

  assign w_mem_acc = mem_valid_i && w_mem_ready;
  assign w_ex_acc  = ex_valid_i && w_ex_ready;

  // Requests targeting x0 complete the handshake but are dropped here.
  assign w_push = (w_mem_acc && (mem_rd_addr_i != 5'd0)) ||
                  (w_ex_acc  && (ex_rd_addr_i  != 5'd0));
  assign w_push_addr = w_mem_acc ? mem_rd_addr_i : ex_rd_addr_i;
  assign w_push_data = w_mem_acc ? mem_rd_data_i : ex_rd_data_i;

  assign w_pop = rst_i && !w_empty && !wb_stall_i;

  assign rd_we_o   = w_pop;
  assign rd_addr_o = w_pop ? r_addr[r_rptr] : 5'd0;
  assign rd_data_o = w_pop ? r_data[r_rptr] : '0;
  assign count_o   = rst_i ? r_count : '0;

  // Write the accepted request into the tail slot.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_wptr] <= w_push_addr;
      r_data[r_wptr] <= w_push_data;
    end
  end

  // Advance pointers and occupancy; reset discards every queued entry.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan valid entries oldest to youngest so the last match is the youngest.
  always_comb begin
    w_rs1_hit  = 1'b0;
    w_rs2_hit  = 1'b0;
    w_rs1_data = '0;
    w_rs2_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + AW'(i);
      if (CW'(i) < r_count) begin
        if (r_addr[w_idx] == rs1_addr_i) begin
          w_rs1_hit  = 1'b1;
          w_rs1_data = r_data[w_idx];
        end
        if (r_addr[w_idx] == rs2_addr_i) begin
          w_rs2_hit  = 1'b1;
          w_rs2_data = r_data[w_idx];
        end
      end
    end
  end

  assign rs1_pending_o  = rst_i && (rs1_addr_i != 5'd0) && w_rs1_hit;
  assign rs2_pending_o  = rst_i && (rs2_addr_i != 5'd0) && w_rs2_hit;
  assign rs1_fwd_data_o = rs1_pending_o ? w_rs1_data : '0;
  assign rs2_fwd_data_o = rs2_pending_o ? w_rs2_data : '0;

endmodule
